// File: rtl/sim_jtag_dtm.sv
// JTAG debug transport module: IEEE 1149.1 TAP (IDCODE/BYPASS/DTMCS/DMI) driven by sampled tclk/tms/tdi.
// Latency: TAP actions on the clk cycle after a tclk rise is seen, tdo registered on the cycle after a fall.
// Backpressure: one DMI request in flight; a scan that touches DMI while busy reports busy (op 3) and is dropped.
// Ports: clk/rst_n (sync, active-low); tclk/tms/tdi in, tdo out; dmi_req_* valid/ready out; dmi_resp_* valid/ready in.
module sim_jtag_dtm #(
  parameter int unsigned ABITS      = 7,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0A6D,
  parameter int unsigned IR_LEN     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tclk,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_op
);

  localparam int unsigned DMI_W = ABITS + 34;
  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(5'h01);
  localparam logic [IR_LEN-1:0] IR_DTMCS  = IR_LEN'(5'h10);
  localparam logic [IR_LEN-1:0] IR_DMI    = IR_LEN'(5'h11);

  localparam logic [1:0] SEL_BYPASS = 2'd0;
  localparam logic [1:0] SEL_IDCODE = 2'd1;
  localparam logic [1:0] SEL_DTMCS  = 2'd2;
  localparam logic [1:0] SEL_DMI    = 2'd3;

  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
  } tap_state_t;

  tap_state_t         r_state, w_state_nxt;
  logic               r_tclk_d;
  logic [IR_LEN-1:0]  r_ir, r_ir_sh;
  logic [DMI_W-1:0]   r_dr, w_dr_cap, w_dr_shift;
  logic [1:0]         r_dmistat;
  logic               r_req_vld, r_resp_rdy, r_tdo;
  logic [ABITS-1:0]   r_addr;
  logic [31:0]        r_data, r_resp_data;
  logic [1:0]         r_op, r_resp_op;
  logic               w_rise, w_fall, w_pend;
  logic [1:0]         w_sel;

  assign w_rise = tclk & ~r_tclk_d;
  assign w_fall = ~tclk & r_tclk_d;
  // Outstanding from the issuing Update-DR until the response is accepted.
  assign w_pend = r_req_vld | r_resp_rdy;

  assign tdo            = r_tdo;
  assign dmi_req_valid  = r_req_vld;
  assign dmi_resp_ready = r_resp_rdy;
  assign dmi_req_addr   = r_addr;
  assign dmi_req_data   = r_data;
  assign dmi_req_op     = r_op;

  always_comb begin
    w_sel = SEL_BYPASS;
    if (r_ir == IR_IDCODE)     w_sel = SEL_IDCODE;
    else if (r_ir == IR_DTMCS) w_sel = SEL_DTMCS;
    else if (r_ir == IR_DMI)   w_sel = SEL_DMI;
  end

  always_comb begin
    w_dr_cap = '0;
    case (w_sel)
      SEL_IDCODE: w_dr_cap = DMI_W'(IDCODE_VAL);
      SEL_DTMCS:  w_dr_cap = DMI_W'({17'b0, 3'd1, r_dmistat, 6'(ABITS), 4'd1});
      SEL_DMI: begin
        if (w_pend) w_dr_cap = {r_addr, r_data, 2'd3};
        else        w_dr_cap = {r_addr, r_resp_data, (r_dmistat != 2'd0) ? r_dmistat : r_resp_op};
      end
      default:    w_dr_cap = '0;
    endcase
  end

  // Shared shift register: tdi lands at the top bit of the selected width; bits above it are don't-care.
  always_comb begin
    w_dr_shift = r_dr >> 1;
    case (w_sel)
      SEL_IDCODE, SEL_DTMCS: w_dr_shift[31]       = tdi;
      SEL_DMI:               w_dr_shift[DMI_W-1]  = tdi;
      default:               w_dr_shift[0]        = tdi;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_rise) begin
      case (r_state)
        S_TLR:    w_state_nxt = tms ? S_TLR    : S_RTI;
        S_RTI:    w_state_nxt = tms ? S_SEL_DR : S_RTI;
        S_SEL_DR: w_state_nxt = tms ? S_SEL_IR : S_CAP_DR;
        S_CAP_DR: w_state_nxt = tms ? S_EX1_DR : S_SH_DR;
        S_SH_DR:  w_state_nxt = tms ? S_EX1_DR : S_SH_DR;
        S_EX1_DR: w_state_nxt = tms ? S_UPD_DR : S_PAU_DR;
        S_PAU_DR: w_state_nxt = tms ? S_EX2_DR : S_PAU_DR;
        S_EX2_DR: w_state_nxt = tms ? S_UPD_DR : S_SH_DR;
        S_UPD_DR: w_state_nxt = tms ? S_SEL_DR : S_RTI;
        S_SEL_IR: w_state_nxt = tms ? S_TLR    : S_CAP_IR;
        S_CAP_IR: w_state_nxt = tms ? S_EX1_IR : S_SH_IR;
        S_SH_IR:  w_state_nxt = tms ? S_EX1_IR : S_SH_IR;
        S_EX1_IR: w_state_nxt = tms ? S_UPD_IR : S_PAU_IR;
        S_PAU_IR: w_state_nxt = tms ? S_EX2_IR : S_PAU_IR;
        S_EX2_IR: w_state_nxt = tms ? S_UPD_IR : S_SH_IR;
        S_UPD_IR: w_state_nxt = tms ? S_SEL_DR : S_RTI;
        default:  w_state_nxt = S_TLR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_TLR;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tclk_d    <= 1'b0;
      r_ir        <= IR_IDCODE;
      r_ir_sh     <= '0;
      r_dr        <= '0;
      r_dmistat   <= 2'd0;
      r_req_vld   <= 1'b0;
      r_resp_rdy  <= 1'b0;
      r_tdo       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_op        <= 2'd0;
      r_resp_data <= '0;
      r_resp_op   <= 2'd0;
    end else begin
      r_tclk_d <= tclk;

      // DM handshake first so that TAP actions later in this block take priority on conflicts.
      if (r_req_vld && dmi_req_ready) begin
        r_req_vld  <= 1'b0;
        r_resp_rdy <= 1'b1;
      end
      if (r_resp_rdy && dmi_resp_valid) begin
        r_resp_rdy  <= 1'b0;
        r_resp_data <= dmi_resp_data;
        r_resp_op   <= dmi_resp_op;
        if (dmi_resp_op == 2'd2 && r_dmistat == 2'd0) r_dmistat <= 2'd2;
      end

      if (w_fall) begin
        if (r_state == S_SH_IR)      r_tdo <= r_ir_sh[0];
        else if (r_state == S_SH_DR) r_tdo <= r_dr[0];
        else                         r_tdo <= 1'b0;
      end

      if (w_rise) begin
        case (r_state)
          S_CAP_IR: r_ir_sh <= IR_LEN'(1);
          S_SH_IR:  r_ir_sh <= {tdi, r_ir_sh[IR_LEN-1:1]};
          S_UPD_IR: r_ir    <= r_ir_sh;
          S_CAP_DR: begin
            r_dr <= w_dr_cap;
            if (w_sel == SEL_DMI && w_pend) r_dmistat <= 2'd3;
          end
          S_SH_DR:  r_dr <= w_dr_shift;
          S_UPD_DR: begin
            if (w_sel == SEL_DTMCS) begin
              if (r_dr[16] || r_dr[17]) r_dmistat <= 2'd0;
              if (r_dr[17]) begin
                r_req_vld  <= 1'b0;
                r_resp_rdy <= 1'b0;
              end
            end else if (w_sel == SEL_DMI && r_dmistat == 2'd0) begin
              if (w_pend) begin
                r_dmistat <= 2'd3;
              end else if (r_dr[1:0] == 2'd1 || r_dr[1:0] == 2'd2) begin
                r_addr    <= r_dr[DMI_W-1:34];
                r_data    <= r_dr[33:2];
                r_op      <= r_dr[1:0];
                r_req_vld <= 1'b1;
              end
            end
          end
          default: ;
        endcase
        if (w_state_nxt == S_TLR) r_ir <= IR_IDCODE;
      end
    end
  end

endmodule
